sram_port_arbiter: RTL and testbench
====================================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: req0_rd, req0_wr  in  1 each  port-0 read/write request, held until ack0.
REQ-004 SHALL have ports: req0_addr, req0_wdata  in  32 each  port-0 byte address and write data.
REQ-005 SHALL have ports: req1_rd, req1_wr, req1_addr, req1_wdata  same widths and meaning as port 0.
REQ-006 SHALL have ports: ack0, ack1  out  1 each  one-cycle completion pulse per port.
REQ-007 SHALL have ports: rdata  out  64  registered read data of the last completed read.
REQ-008 SHALL have ports: ctrl_wr_en, ctrl_rd_en  out  1 each  enables to the SRAM controller.
REQ-009 SHALL have ports: ctrl_addr, ctrl_wdata  out  32 each  address/data to the SRAM controller.
REQ-010 SHALL have ports: ctrl_rdata  in  64; ctrl_ready  in  1  controller read data and ready.
REQ-011 SHALL have ports: timeout_err  out  1  sticky flag, set on a watchdog expiry.
REQ-012 SHALL have parameter: TIMEOUT_CYC, default 15, the maximum number of BUSY cycles before an abort.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-014 IDLE: SHALL select a requesting port in IDLE; a port requests when rd or wr is high.
  - On the selection cycle it SHALL latch that port's addr, wdata and op, then go to BUSY.
REQ-015 If both rd and wr are high on a port, the request SHALL be treated as a write.
REQ-016 Arbitration SHALL be round-robin.
  - On simultaneous requests, the port not granted last SHALL win.
  - last_grant SHALL update on every grant.
REQ-017 BUSY: ctrl_wr_en or ctrl_rd_en (per latched op) SHALL be driven high from registered state.
  - ctrl_addr and ctrl_wdata SHALL be driven from latches; they are stable for the whole transaction.
REQ-018 BUSY SHALL set a seen_low flag when ctrl_ready=0.
  - Completion SHALL be the first cycle with ctrl_ready=1 and seen_low=1.
  - ctrl_ready=1 before seen_low SHALL be ignored.
REQ-019 On completion: for a read, rdata SHALL load ctrl_rdata; the FSM SHALL go to RESP.
REQ-020 RESP SHALL deassert both enables and pulse the granted ack for exactly one cycle, then go to IDLE.
REQ-021 Minimum spacing SHALL be one IDLE cycle between transactions; no back-to-back grants without IDLE.
REQ-022 A requester dropping its request mid-BUSY SHALL NOT abort the transaction; ack SHALL still pulse.
REQ-023 Outside BUSY, ctrl_wr_en=ctrl_rd_en=0 and ctrl_addr/ctrl_wdata SHALL hold their last latched values.
REQ-024 A watchdog counter SHALL clear on entry to BUSY and increment on each BUSY cycle.
  - On reaching TIMEOUT_CYC: set timeout_err, go to RESP, pulse ack, leave rdata unchanged.
REQ-025 timeout_err SHALL clear only on reset.

Reset
REQ-026 rst_n low SHALL asynchronously force the following, including mid-transaction:
  - state=IDLE, last_grant=port 1 (so port 0 wins the first tie);
  - ack0=ack1=0, ctrl_wr_en=ctrl_rd_en=0;
  - ctrl_addr=0, ctrl_wdata=0, rdata=0;
  - timeout_err=0, watchdog=0, seen_low=0.

Configuration
REQ-027 With macro SRAM_ARB_FIXED_PRIO_EN defined, port 0 SHALL always win simultaneous requests and last_grant SHALL be unused.
REQ-028 Without SRAM_ARB_FIXED_PRIO_EN, round-robin per REQ-016 SHALL apply.

Verification
REQ-029 The bench SHALL cover:
  - Port-0 read 0x0000_0400; model ready low 4 cycles then high 1 -> rdata=model data, ack0 pulses once, ack1=0.
  - Simultaneous wr on both ports after reset -> port 0 served first, then port 1. With SRAM_ARB_FIXED_PRIO_EN and port 0 re-requesting -> port 0 served twice before port 1.
  - Port-1 write addr 0x0000_0408, wdata 0xDEAD_BEEF -> ctrl_wr_en high throughout BUSY; ctrl_addr/ctrl_wdata stable even when req1 inputs change mid-transaction.
  - Model holds ctrl_ready=0 forever -> after 15 BUSY cycles, timeout_err=1, ack pulses, next request still served.
  - rst_n low during BUSY -> enables drop immediately; all outputs at reset values; no ack.
  - rd and wr both high on port 0 -> write issued (ctrl_wr_en=1, ctrl_rd_en=0).

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of a single SRAM controller.
// One transaction at a time: IDLE selects a requester, BUSY drives the
// controller until it completes (or the watchdog fires), RESP pulses the ack.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req{0,1}_rd/_wr/_addr/_wdata     requester ports, held until ack
//   ack0, ack1                       one-cycle completion pulses
//   rdata                            data of the last completed read
//   ctrl_rd_en, ctrl_wr_en           controller enables (high only in BUSY)
//   ctrl_addr, ctrl_wdata            latched address/data to controller
//   ctrl_rdata, ctrl_ready           controller read data and ready
//   timeout_err                      sticky watchdog-expiry flag
//
// Build option: SRAM_ARB_FIXED_PRIO_EN -> port 0 always wins a tie;
// otherwise ties are resolved round-robin.
module sram_port_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_rd,
    input  logic        req0_wr,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic        req1_rd,
    input  logic        req1_wr,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        ack0,
    output logic        ack1,
    output logic [63:0] rdata,
    output logic        ctrl_wr_en,
    output logic        ctrl_rd_en,
    output logic [31:0] ctrl_addr,
    output logic [31:0] ctrl_wdata,
    input  logic [63:0] ctrl_rdata,
    input  logic        ctrl_ready,
    output logic        timeout_err
);

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned RW   = 64;
    localparam int unsigned WD_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state, state_nxt;
    logic            grant, grant_nxt;
    logic            op_wr, op_wr_nxt;
    logic            seen_low, seen_low_nxt;
    logic [WD_W-1:0] wd, wd_nxt;
    logic            ack0_nxt, ack1_nxt;
    logic            wr_en_nxt, rd_en_nxt;
    logic [AW-1:0]   addr_nxt;
    logic [DW-1:0]   wdata_nxt;
    logic [RW-1:0]   rdata_nxt;
    logic            timeout_nxt;
    logic            finish;
    logic            req0, req1, sel;
`ifndef SRAM_ARB_FIXED_PRIO_EN
    logic            last_grant, last_grant_nxt;
`endif

    assign req0 = req0_rd | req0_wr;
    assign req1 = req1_rd | req1_wr;

    // Port selection for a grant in IDLE
`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign sel = ~req0;
`else
    assign sel = (req0 && req1) ? ~last_grant : req1;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        op_wr_nxt    = op_wr;
        seen_low_nxt = seen_low;
        wd_nxt       = wd;
        ack0_nxt     = 1'b0;
        ack1_nxt     = 1'b0;
        wr_en_nxt    = ctrl_wr_en;
        rd_en_nxt    = ctrl_rd_en;
        addr_nxt     = ctrl_addr;
        wdata_nxt    = ctrl_wdata;
        rdata_nxt    = rdata;
        timeout_nxt  = timeout_err;
        finish       = 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
        last_grant_nxt = last_grant;
`endif
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant_nxt    = sel;
                    // rd+wr together is a write
                    op_wr_nxt    = sel ? req1_wr : req0_wr;
                    addr_nxt     = sel ? req1_addr : req0_addr;
                    wdata_nxt    = sel ? req1_wdata : req0_wdata;
                    wr_en_nxt    = sel ? req1_wr : req0_wr;
                    rd_en_nxt    = sel ? ~req1_wr : ~req0_wr;
                    wd_nxt       = '0;
                    seen_low_nxt = 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
                    last_grant_nxt = sel;
`endif
                    state_nxt    = BUSY;
                end
            end
            BUSY: begin
                wd_nxt = wd + WD_W'(1);
                if (!ctrl_ready) begin
                    seen_low_nxt = 1'b1;
                end
                // Ready only counts once it has been seen low in this transaction
                if (ctrl_ready && seen_low) begin
                    finish = 1'b1;
                    if (!op_wr) begin
                        rdata_nxt = ctrl_rdata;
                    end
                end else if (wd_nxt == WD_W'(TIMEOUT_CYC)) begin
                    finish      = 1'b1;
                    timeout_nxt = 1'b1;
                end
                if (finish) begin
                    wr_en_nxt = 1'b0;
                    rd_en_nxt = 1'b0;
                    ack0_nxt  = ~grant;
                    ack1_nxt  = grant;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= 1'b0;
            op_wr       <= 1'b0;
            seen_low    <= 1'b0;
            wd          <= '0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            ctrl_wr_en  <= 1'b0;
            ctrl_rd_en  <= 1'b0;
            ctrl_addr   <= '0;
            ctrl_wdata  <= '0;
            rdata       <= '0;
            timeout_err <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_grant  <= 1'b1;
`endif
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            op_wr       <= op_wr_nxt;
            seen_low    <= seen_low_nxt;
            wd          <= wd_nxt;
            ack0        <= ack0_nxt;
            ack1        <= ack1_nxt;
            ctrl_wr_en  <= wr_en_nxt;
            ctrl_rd_en  <= rd_en_nxt;
            ctrl_addr   <= addr_nxt;
            ctrl_wdata  <= wdata_nxt;
            rdata       <= rdata_nxt;
            timeout_err <= timeout_nxt;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_grant  <= last_grant_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a small SRAM-controller model.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_rd, req0_wr, req1_rd, req1_wr;
    logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic        ack0, ack1;
    logic [63:0] rdata;
    logic        ctrl_wr_en, ctrl_rd_en;
    logic [31:0] ctrl_addr, ctrl_wdata;
    logic [63:0] ctrl_rdata;
    logic        ctrl_ready;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    localparam int SECOND_PORT = 0;
    localparam int THIRD_PORT  = 1;
`else
    localparam int SECOND_PORT = 1;
    localparam int THIRD_PORT  = 0;
`endif

    always #5 clk = ~clk;

    sram_port_arbiter #(.TIMEOUT_CYC(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_rd(req0_rd), .req0_wr(req0_wr), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_rd(req1_rd), .req1_wr(req1_wr), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .ack0(ack0), .ack1(ack1), .rdata(rdata),
        .ctrl_wr_en(ctrl_wr_en), .ctrl_rd_en(ctrl_rd_en),
        .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
        .ctrl_rdata(ctrl_rdata), .ctrl_ready(ctrl_ready),
        .timeout_err(timeout_err)
    );

    // Controller model: ready low for low_cyc enabled cycles, then high;
    // 'early' adds a spurious ready on the first enabled cycle; 'never' holds it low.
    int busy_cnt = 0;
    int low_cyc  = 4;
    bit early    = 1'b0;
    bit never    = 1'b0;

    always @(posedge clk) begin
        if (ctrl_rd_en || ctrl_wr_en) busy_cnt <= busy_cnt + 1;
        else                          busy_cnt <= 0;
    end

    assign ctrl_ready = never ? 1'b0 :
                        !(ctrl_rd_en || ctrl_wr_en) ? 1'b1 :
                        ((early && busy_cnt == 0) || busy_cnt >= low_cyc);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Results of the last serve() call
    int          got_port;
    int          en_cycles, wr_cycles, rd_cycles;
    bit          stable, ack_after, gap_en, both_ack, scramble;
    logic [31:0] a0, d0;

    // Follow one transaction up to its ack, then one more cycle (the IDLE gap)
    task automatic serve(input int max_cyc);
        bit first;
        got_port = -1; en_cycles = 0; wr_cycles = 0; rd_cycles = 0;
        stable = 1'b1; first = 1'b1; ack_after = 1'b0; gap_en = 1'b0; both_ack = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (ctrl_rd_en || ctrl_wr_en) begin
                en_cycles++;
                if (ctrl_wr_en) wr_cycles++;
                if (ctrl_rd_en) rd_cycles++;
                if (first) begin
                    a0 = ctrl_addr; d0 = ctrl_wdata; first = 1'b0;
                end else if (ctrl_addr !== a0 || ctrl_wdata !== d0) begin
                    stable = 1'b0;
                end
                if (scramble && en_cycles == 2) begin
                    req1_addr = 32'hFFFF_FFFF; req1_wdata = 32'h0; req1_wr = 1'b0;
                end
            end
            if (ack0 || ack1) begin
                got_port = ack1 ? 1 : 0;
                both_ack = ack0 && ack1;
                if (ack0) begin req0_rd = 1'b0; req0_wr = 1'b0; end
                if (ack1) begin req1_rd = 1'b0; req1_wr = 1'b0; end
                @(negedge clk);
                ack_after = ack0 || ack1;
                gap_en    = ctrl_rd_en || ctrl_wr_en;
                return;
            end
        end
    endtask

    initial begin
        bit any_ack;
        rst_n = 1'b0;
        req0_rd = 0; req0_wr = 0; req0_addr = 0; req0_wdata = 0;
        req1_rd = 0; req1_wr = 0; req1_addr = 0; req1_wdata = 0;
        ctrl_rdata = 64'h0; scramble = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", {ack0, ack1}, 0);
        check("rst_en", {ctrl_wr_en, ctrl_rd_en}, 0);
        check("rst_addr", ctrl_addr, 0);
        check("rst_rdata", rdata, 0);
        check("rst_terr", timeout_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Simultaneous writes right after reset
        low_cyc = 2;
        req0_wr = 1; req0_addr = 32'h100; req0_wdata = 32'hA0;
        req1_wr = 1; req1_addr = 32'h104; req1_wdata = 32'hB1;
        serve(40);
        check("tie1_port", 64'(got_port), 0);
        check("tie1_busy", en_cycles, 3);
        check("tie1_wdata", ctrl_wdata, 32'hA0);
        check("tie1_onepulse", ack_after, 0);
        check("tie1_gap", gap_en, 0);
        req0_wr = 1;
        serve(40);
        check("tie2_port", 64'(got_port), 64'(SECOND_PORT));
        check("tie2_both", both_ack, 0);
        serve(40);
        check("tie3_port", 64'(got_port), 64'(THIRD_PORT));

        // Port-0 read of 0x400
        low_cyc = 4; ctrl_rdata = 64'h0123_4567_89AB_CDEF;
        req0_rd = 1; req0_addr = 32'h400;
        serve(40);
        check("rd_port", 64'(got_port), 0);
        check("rd_busy", en_cycles, 5);
        check("rd_rdcyc", rd_cycles, 5);
        check("rd_wrcyc", wr_cycles, 0);
        check("rd_rdata", rdata, 64'h0123_4567_89AB_CDEF);
        check("rd_onepulse", ack_after, 0);
        check("rd_addr", ctrl_addr, 32'h400);

        // Port-1 write, early ready ignored, inputs scrambled and dropped mid-BUSY
        early = 1'b1; scramble = 1'b1; ctrl_rdata = 64'h1111;
        req1_wr = 1; req1_addr = 32'h408; req1_wdata = 32'hDEAD_BEEF;
        serve(40);
        early = 1'b0; scramble = 1'b0;
        check("wr_port", 64'(got_port), 1);
        check("wr_busy", en_cycles, 5);
        check("wr_wrcyc", wr_cycles, 5);
        check("wr_rdcyc", rd_cycles, 0);
        check("wr_stable", stable, 1);
        check("wr_addr", ctrl_addr, 32'h408);
        check("wr_wdata", ctrl_wdata, 32'hDEAD_BEEF);
        check("wr_rdata_kept", rdata, 64'h0123_4567_89AB_CDEF);

        // rd and wr together on port 0 -> write
        low_cyc = 3;
        req0_rd = 1; req0_wr = 1; req0_addr = 32'h10; req0_wdata = 32'h77;
        serve(40);
        check("rw_port", 64'(got_port), 0);
        check("rw_wrcyc", wr_cycles, 4);
        check("rw_rdcyc", rd_cycles, 0);

        // Watchdog expiry
        never = 1'b1; ctrl_rdata = 64'h5555_5555_5555_5555;
        req0_rd = 1; req0_addr = 32'h600;
        serve(40);
        never = 1'b0;
        check("to_port", 64'(got_port), 0);
        check("to_busy", en_cycles, 15);
        check("to_terr", timeout_err, 1);
        check("to_rdata_kept", rdata, 64'h0123_4567_89AB_CDEF);
        ctrl_rdata = 64'hCAFE_F00D_0000_0001; low_cyc = 3;
        req1_rd = 1; req1_addr = 32'h700;
        serve(40);
        check("to_next_port", 64'(got_port), 1);
        check("to_next_rdata", rdata, 64'hCAFE_F00D_0000_0001);
        check("to_sticky", timeout_err, 1);

        // Reset in the middle of BUSY
        never = 1'b1;
        req0_rd = 1; req0_addr = 32'h500; req0_wdata = 32'h99;
        repeat (4) @(negedge clk);
        check("mid_pre_en", ctrl_rd_en, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_en", {ctrl_wr_en, ctrl_rd_en}, 0);
        check("mid_ack", {ack0, ack1}, 0);
        check("mid_addr", ctrl_addr, 0);
        check("mid_wdata", ctrl_wdata, 0);
        check("mid_rdata", rdata, 0);
        check("mid_terr", timeout_err, 0);
        req0_rd = 0; never = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        any_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ack0 || ack1) any_ack = 1'b1;
        end
        check("mid_noack", any_ack, 0);

        // After reset, a tie again goes to port 0 first
        low_cyc = 2;
        req0_wr = 1; req0_addr = 32'h20; req0_wdata = 32'h1;
        req1_wr = 1; req1_addr = 32'h24; req1_wdata = 32'h2;
        serve(40);
        check("rtie1_port", 64'(got_port), 0);
        serve(40);
        check("rtie2_port", 64'(got_port), 1);
        check("rtie2_wdata", ctrl_wdata, 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
